// File: rtl/pkg_dvi.sv
// DVI timing constants shared by the scanout path and the framebuffer arbiter.
`timescale 1ns/1ps
package pkg_dvi;
    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;
endpackage

// File: rtl/pkg_mig_framebuffer.sv
// Shared framebuffer/MIG definitions: address layout, MIG commands, arbiter states.
`timescale 1ns/1ps
package pkg_mig_framebuffer;
    localparam logic [2:0]  MIG_CMD_WRITE   = 3'b000;
    localparam logic [2:0]  MIG_CMD_READ    = 3'b001;
    localparam int          BYTES_PER_PIXEL = 4;
    localparam logic [12:0] ADDR_READ_STEP  = 13'd16;
    localparam logic [12:0] COLUMN_ADDR_MAX = 13'(pkg_dvi::H_ACTIVE * BYTES_PER_PIXEL) - ADDR_READ_STEP;

    // {buffer, row, 16-byte column, byte within burst}; 25 bits, zero-extended onto app_addr
    typedef struct packed {
        logic        buffer;
        logic [10:0] row;
        logic [8:0]  column;
        logic [3:0]  pixel_data;
    } framebuffer_addr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_LINE = 2'd1,
        WR      = 2'd2
    } fb_arb_state_t;

    function automatic framebuffer_addr_t fb_addr(input logic buffer, input logic [10:0] row,
                                                  input logic [12:0] col);
        framebuffer_addr_t a;
        a.buffer     = buffer;
        a.row        = row;
        a.column     = col[12:4];
        a.pixel_data = col[3:0];
        return a;
    endfunction
endpackage

// File: rtl/fb_mig_arbiter.sv
// Shares the MIG command/write port between scanout line reads and pixel writes; owns front/back
// buffer selection. Define FB_ARB_DOUBLE_BUFFER_EN for vsync-deferred buffer swapping.
`timescale 1ns/1ps
module fb_mig_arbiter
    import pkg_mig_framebuffer::*;
#(
    parameter int MIG_ADDR_WIDTH = 30,
    parameter int MIG_DATA_WIDTH = 128,
    parameter int H_ACTIVE       = pkg_dvi::H_ACTIVE
) (
    input  logic                        ui_clk,
    input  logic                        ui_rst_n,
    input  logic                        init_calib_complete,
    input  logic                        vsync,
    input  logic                        swap_req,
    output logic                        swap_ack,
    output logic                        front_buffer,
    input  logic                        rd_line_valid,
    output logic                        rd_line_ready,
    input  logic [10:0]                 rd_line_row,
    output logic                        rd_line_done,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [10:0]                 wr_row,
    input  logic [12:0]                 wr_col,
    input  logic [MIG_DATA_WIDTH-1:0]   wr_data,
    input  logic [MIG_DATA_WIDTH/8-1:0] wr_mask,
    output logic [MIG_ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]                  app_cmd,
    output logic                        app_en,
    input  logic                        app_rdy,
    output logic [MIG_DATA_WIDTH-1:0]   app_wdf_data,
    output logic [MIG_DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                        app_wdf_wren,
    output logic                        app_wdf_end,
    input  logic                        app_wdf_rdy,
    output logic [1:0]                  dbg_state
);
    // Handshakes: a command is taken on a cycle where app_en&app_rdy (or wren&wdf_rdy) are both
    // high; rd_line_ready / wr_ready are single-cycle pulses and the client drops valid on seeing them.
    localparam int          MASK_WIDTH = MIG_DATA_WIDTH / 8;
    localparam logic [12:0] COL_LAST   = 13'(H_ACTIVE * BYTES_PER_PIXEL) - ADDR_READ_STEP;

    fb_arb_state_t             state_q, state_d;
    logic                      rd_buf_q, rd_buf_d;
    logic [10:0]               row_q, row_d;
    logic [12:0]               col_q, col_d;
    logic                      cmd_done_q, cmd_done_d;
    logic                      data_done_q, data_done_d;
    logic                      app_en_q, app_en_d;
    logic [2:0]                app_cmd_q, app_cmd_d;
    logic [MIG_ADDR_WIDTH-1:0] app_addr_q, app_addr_d;
    logic [MIG_DATA_WIDTH-1:0] app_wdf_data_q, app_wdf_data_d;
    logic [MASK_WIDTH-1:0]     app_wdf_mask_q, app_wdf_mask_d;
    logic                      app_wdf_wren_q, app_wdf_wren_d;
    logic                      app_wdf_end_q, app_wdf_end_d;
    logic                      rd_line_ready_q, rd_line_ready_d;
    logic                      rd_line_done_q, rd_line_done_d;
    logic                      wr_ready_q, wr_ready_d;
    logic                      front_buf;
    logic                      wr_buf;
    logic                      cmd_acc;
    logic                      data_acc;

`ifdef FB_ARB_DOUBLE_BUFFER_EN
    logic front_q, front_d;
    logic swap_pending_q, swap_pending_d;
    logic swap_ack_q, swap_ack_d;

    // A swap_req coinciding with vsync still swaps on that vsync
    always_comb begin
        swap_pending_d = swap_pending_q | swap_req;
        front_d        = front_q;
        swap_ack_d     = 1'b0;
        if (vsync && swap_pending_d) begin
            front_d        = ~front_q;
            swap_ack_d     = 1'b1;
            swap_pending_d = 1'b0;
        end
    end

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            front_q        <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_ack_q     <= 1'b0;
        end else begin
            front_q        <= front_d;
            swap_pending_q <= swap_pending_d;
            swap_ack_q     <= swap_ack_d;
        end
    end

    assign front_buf = front_q;
    assign wr_buf    = ~front_q;
    assign swap_ack  = swap_ack_q;
`else
    logic unused_swap_inputs;
    assign unused_swap_inputs = swap_req | vsync;
    assign front_buf = 1'b0;
    assign wr_buf    = 1'b0;
    assign swap_ack  = 1'b0;
`endif

    assign cmd_acc  = app_en_q & app_rdy;
    assign data_acc = app_wdf_wren_q & app_wdf_rdy;

    always_comb begin
        state_d         = state_q;
        rd_buf_d        = rd_buf_q;
        row_d           = row_q;
        col_d           = col_q;
        cmd_done_d      = cmd_done_q;
        data_done_d     = data_done_q;
        app_en_d        = 1'b0;
        app_cmd_d       = app_cmd_q;
        app_addr_d      = app_addr_q;
        app_wdf_data_d  = app_wdf_data_q;
        app_wdf_mask_d  = app_wdf_mask_q;
        app_wdf_wren_d  = 1'b0;
        app_wdf_end_d   = 1'b0;
        rd_line_ready_d = 1'b0;
        rd_line_done_d  = 1'b0;
        wr_ready_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_calib_complete) begin
                    if (rd_line_valid) begin
                        rd_line_ready_d = 1'b1;
                        rd_buf_d        = front_buf;
                        row_d           = rd_line_row;
                        col_d           = '0;
                        state_d         = RD_LINE;
                    // wr_valid is still high during the wr_ready cycle; do not re-accept it
                    end else if (wr_valid && !wr_ready_q) begin
                        app_en_d       = 1'b1;
                        app_cmd_d      = MIG_CMD_WRITE;
                        app_addr_d     = MIG_ADDR_WIDTH'(fb_addr(wr_buf, wr_row, wr_col));
                        app_wdf_data_d = wr_data;
                        app_wdf_mask_d = wr_mask;
                        app_wdf_wren_d = 1'b1;
                        app_wdf_end_d  = 1'b1;
                        cmd_done_d     = 1'b0;
                        data_done_d    = 1'b0;
                        state_d        = WR;
                    end
                end
            end
            RD_LINE: begin
                app_cmd_d = MIG_CMD_READ;
                if (cmd_acc && col_q == COL_LAST) begin
                    rd_line_done_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    if (cmd_acc) begin
                        col_d = col_q + ADDR_READ_STEP;
                    end
                    app_en_d   = 1'b1;
                    app_addr_d = MIG_ADDR_WIDTH'(fb_addr(rd_buf_q, row_q, col_d));
                end
            end
            WR: begin
                cmd_done_d  = cmd_done_q | cmd_acc;
                data_done_d = data_done_q | data_acc;
                if (cmd_done_d && data_done_d) begin
                    wr_ready_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    app_en_d       = ~cmd_done_d;
                    app_wdf_wren_d = ~data_done_d;
                    app_wdf_end_d  = ~data_done_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            state_q         <= IDLE;
            rd_buf_q        <= 1'b0;
            row_q           <= '0;
            col_q           <= '0;
            cmd_done_q      <= 1'b0;
            data_done_q     <= 1'b0;
            app_en_q        <= 1'b0;
            app_cmd_q       <= 3'b000;
            app_addr_q      <= '0;
            app_wdf_data_q  <= '0;
            app_wdf_mask_q  <= '0;
            app_wdf_wren_q  <= 1'b0;
            app_wdf_end_q   <= 1'b0;
            rd_line_ready_q <= 1'b0;
            rd_line_done_q  <= 1'b0;
            wr_ready_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_buf_q        <= rd_buf_d;
            row_q           <= row_d;
            col_q           <= col_d;
            cmd_done_q      <= cmd_done_d;
            data_done_q     <= data_done_d;
            app_en_q        <= app_en_d;
            app_cmd_q       <= app_cmd_d;
            app_addr_q      <= app_addr_d;
            app_wdf_data_q  <= app_wdf_data_d;
            app_wdf_mask_q  <= app_wdf_mask_d;
            app_wdf_wren_q  <= app_wdf_wren_d;
            app_wdf_end_q   <= app_wdf_end_d;
            rd_line_ready_q <= rd_line_ready_d;
            rd_line_done_q  <= rd_line_done_d;
            wr_ready_q      <= wr_ready_d;
        end
    end

    assign front_buffer  = front_buf;
    assign rd_line_ready = rd_line_ready_q;
    assign rd_line_done  = rd_line_done_q;
    assign wr_ready      = wr_ready_q;
    assign app_addr      = app_addr_q;
    assign app_cmd       = app_cmd_q;
    assign app_en        = app_en_q;
    assign app_wdf_data  = app_wdf_data_q;
    assign app_wdf_mask  = app_wdf_mask_q;
    assign app_wdf_wren  = app_wdf_wren_q;
    assign app_wdf_end   = app_wdf_end_q;
    assign dbg_state     = state_q;
endmodule
